sp_pe_mac: RTL and testbench
============================

# sp_pe_mac

Multi-lane sparse processing element that computes one output row of H·W for the SPMM stage. It consumes one CSR row of H as a row header followed by a stream of (column index, value) nonzeros, and fetches the matching row of W across NUM_LANES output features. It accumulates per lane in signed fixed point, with optional saturation, and emits the finished WH row with its node metadata over a valid/ready handshake. It sits between the H CSR reader / weight BRAM and the WH buffer feeding DMVM.

## Interface
- DATA_WIDTH, 8: signed H nonzero value width
- WGT_WIDTH, 8: signed weight element width
- ACC_WIDTH, 12: signed per-lane result width
- NUM_LANES, 16: output features computed in parallel
- COL_IDX_WIDTH, 11: H column index width, equal to the weight row address width
- ROW_LEN_WIDTH, 11: nonzeros-per-row count width
- NUM_NODE_WIDTH, 8: subgraph node-count metadata width
- SATURATE, 1: 1 = clamp on overflow, 0 = two's-complement wrap

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- mode_i  in  1  0 = binary H (add the weight, ignore val), 1 = multiply val·weight; sampled at row accept
- row_vld_i / row_rdy_o  in/out  1  row header handshake
- row_len_i  in  ROW_LEN_WIDTH  nonzeros in this row; 0 is legal
- num_node_i  in  NUM_NODE_WIDTH  node-count metadata for the row
- src_flag_i  in  1  source-node flag for the row
- nz_vld_i / nz_rdy_o  in/out  1  nonzero handshake
- col_idx_i  in  COL_IDX_WIDTH  column of the nonzero
- val_i  in  DATA_WIDTH  signed nonzero value
- wgt_addr_o  out  COL_IDX_WIDTH  weight BRAM read address, driven combinationally as col_idx_i
- wgt_dout_i  in  NUM_LANES·WGT_WIDTH  weight row; lane k is bits [k·WGT_WIDTH +: WGT_WIDTH]; 1-cycle read latency
- res_vld_o / res_rdy_i  out/in  1  result handshake
- res_o  out  NUM_LANES·ACC_WIDTH  per-lane results, packed in the same lane order as wgt_dout_i
- num_node_o, src_flag_o  out  metadata of the row being presented
- ovf_o  out  1  at least one lane overflowed in this row; valid with res_vld_o

## Operation
- States:
  - IDLE: row_rdy_o=1.
  - ACC: nz_rdy_o=1.
  - WAIT: the last weight is in flight.
  - OUT: res_vld_o=1.
- Transitions:
  - IDLE→ACC on a row handshake with row_len_i>0.
  - IDLE→OUT on a row handshake with row_len_i=0.
  - ACC→WAIT on the handshake of the row_len-th nonzero.
  - WAIT→OUT unconditionally.
  - OUT→IDLE on res_vld_o&&res_rdy_i.
- Row accept: latch row_len, mode, num_node and src_flag; clear all accumulators, the nonzero counter and ovf. num_node_o and src_flag_o show the latched values from accept until the next accept.
- Nonzero accept: register val_i and a valid bit. In the next cycle, combine the registered val with wgt_dout_i and add the result into every lane.
- Cycles with nz_vld_i=0 are bubbles: no accumulation, no count.
- Nonzero handshakes outside ACC do not occur, because nz_rdy_o=0 there.
- Lane product:
  - mode 0: sign-extended weight.
  - mode 1: signed val × signed weight, full DATA_WIDTH+WGT_WIDTH precision.
- Lane sum:
  - Compute acc+product at full precision.
  - If the sum is outside [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1]:
    - SATURATE=1: clamp to the nearest bound.
    - SATURATE=0: keep the low ACC_WIDTH bits.
  - Either way, set ovf sticky for the row.
- res_o, ovf_o, num_node_o and src_flag_o hold stable while res_vld_o=1 and res_rdy_i=0.
- Reset values: state IDLE, row_rdy_o=1, nz_rdy_o=0, res_vld_o=0, res_o=0, ovf_o=0, num_node_o=0, src_flag_o=0, internal counter and pipeline valid=0.
- Reset mid-row is asynchronous: it discards the partial sums and returns to IDLE. No result is emitted for that row.

## Timing
- The row header is accepted at cycle r. The first nonzero can be accepted at r+1.
- The last nonzero is accepted at t. The weight is valid at t+1 and accumulates at the t+1→t+2 edge. res_vld_o=1 from t+2.
- A zero-length row accepted at r gives res_vld_o=1 at r+1 with res_o=0.
- Throughput: one nonzero per cycle, plus 3 cycles of row overhead (accept, WAIT, OUT) when res_rdy_i is held at 1.
- row_rdy_o is 1 in the cycle after the result handshake, not in the same cycle.

## Test plan
Parameters for all scenarios: NUM_LANES=2, ACC_WIDTH=12, SATURATE=1.
- Mode 0, row_len=3, weight lanes (1,−2), (3,4), (−5,6), nz_vld always 1, res_rdy=1 → res=(−1,8), ovf=0, res_vld 2 cycles after the 3rd nonzero accept.
- Mode 1, row_len=2, vals 3 and −2, weights (10,−7) then (4,5) → res=(22,−31); with nz_vld gaps of 2 idle cycles between nonzeros → same result, res_vld 2 cycles after the last accept.
- Mode 1, 20 nonzeros of val=127 × weight (127,−128) → lanes clamp to 2047 and −2048, ovf_o=1. Repeat with SATURATE=0 → wrapped low 12 bits, ovf_o=1.
- row_len=0 with num_node=5, src_flag=1 → res_vld next cycle, res=(0,0), num_node_o=5, src_flag_o=1.
- res_rdy held 0 for 4 cycles in OUT → outputs stable, row_rdy_o=0, no nonzero accepted; after release, the next row's first nonzero is accepted 2 cycles after the result handshake.
- rst_n asserted mid-row after 2 of 5 nonzeros → immediate IDLE, all outputs at reset values. The following row (row_len=1, weights (7,7), mode 0) gives exactly (7,7).

Source files
------------

// File: rtl/sp_pe_mac_if.sv
// Bus bundle for the sparse processing element (sp_pe_mac).
//
// Carries four groups of signals:
//   - row header:  mode_i, row_vld_i/row_rdy_o, row_len_i, num_node_i, src_flag_i
//   - nonzeros:    nz_vld_i/nz_rdy_o, col_idx_i, val_i
//   - weight BRAM: wgt_addr_o (read address), wgt_dout_i (lane-packed weight row)
//   - result:      res_vld_o/res_rdy_i, res_o, num_node_o, src_flag_o, ovf_o
// The _i/_o suffixes are taken from the processing element's point of view.
//
// Modports:
//   slave  - the processing element
//   master - the surrounding logic: CSR reader, weight BRAM and WH buffer
interface sp_pe_mac_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int WGT_WIDTH      = 8,
    parameter int ACC_WIDTH      = 12,
    parameter int NUM_LANES      = 16,
    parameter int COL_IDX_WIDTH  = 11,
    parameter int ROW_LEN_WIDTH  = 11,
    parameter int NUM_NODE_WIDTH = 8
);
    logic                            mode_i;
    logic                            row_vld_i;
    logic                            row_rdy_o;
    logic [ROW_LEN_WIDTH-1:0]        row_len_i;
    logic [NUM_NODE_WIDTH-1:0]       num_node_i;
    logic                            src_flag_i;
    logic                            nz_vld_i;
    logic                            nz_rdy_o;
    logic [COL_IDX_WIDTH-1:0]        col_idx_i;
    logic signed [DATA_WIDTH-1:0]    val_i;
    logic [COL_IDX_WIDTH-1:0]        wgt_addr_o;
    logic [NUM_LANES*WGT_WIDTH-1:0]  wgt_dout_i;
    logic                            res_vld_o;
    logic                            res_rdy_i;
    logic [NUM_LANES*ACC_WIDTH-1:0]  res_o;
    logic [NUM_NODE_WIDTH-1:0]       num_node_o;
    logic                            src_flag_o;
    logic                            ovf_o;

    modport slave (
        input  mode_i, row_vld_i, row_len_i, num_node_i, src_flag_i,
        input  nz_vld_i, col_idx_i, val_i, wgt_dout_i, res_rdy_i,
        output row_rdy_o, nz_rdy_o, wgt_addr_o,
        output res_vld_o, res_o, num_node_o, src_flag_o, ovf_o
    );

    modport master (
        output mode_i, row_vld_i, row_len_i, num_node_i, src_flag_i,
        output nz_vld_i, col_idx_i, val_i, wgt_dout_i, res_rdy_i,
        input  row_rdy_o, nz_rdy_o, wgt_addr_o,
        input  res_vld_o, res_o, num_node_o, src_flag_o, ovf_o
    );
endinterface

// File: rtl/sp_pe_mac.sv
// Multi-lane sparse processing element: computes one output row of H*W.
//
// A CSR row header is accepted first, then row_len (column, value) nonzeros.
// For each nonzero, the matching weight row is read from the weight BRAM, which
// has a 1-cycle latency. The weight row is added into NUM_LANES signed
// accumulators in one of two ways:
//   - mode 0 (binary H): the weight is added directly.
//   - mode 1:            val * weight is added.
// The finished row is presented on a valid/ready result port together with the
// row metadata.
//
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset. It drops any partial row.
//   bus    - sp_pe_mac_if.slave, which carries:
//              - row header handshake and metadata
//              - nonzero handshake
//              - weight BRAM address and data
//              - result handshake, with res_o, num_node_o, src_flag_o, ovf_o
module sp_pe_mac #(
    parameter int DATA_WIDTH     = 8,
    parameter int WGT_WIDTH      = 8,
    parameter int ACC_WIDTH      = 12,
    parameter int NUM_LANES      = 16,
    parameter int COL_IDX_WIDTH  = 11,
    parameter int ROW_LEN_WIDTH  = 11,
    parameter int NUM_NODE_WIDTH = 8,
    parameter int SATURATE       = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    sp_pe_mac_if.slave  bus
);
    localparam int PROD_W = DATA_WIDTH + WGT_WIDTH;
    // One guard bit above the wider operand keeps acc + product exact.
    localparam int SUM_W  = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;

    typedef enum logic [1:0] {IDLE, ACC, WAIT, OUT} state_t;

    state_t                         state, state_nxt;
    logic                           row_rdy, nz_rdy, res_vld;
    logic                           row_fire, nz_fire, res_fire, last_nz;

    logic [ROW_LEN_WIDTH-1:0]       row_len_q;
    logic [ROW_LEN_WIDTH-1:0]       nz_cnt_q;
    logic                           mode_q;
    logic [NUM_NODE_WIDTH-1:0]      num_node_q;
    logic                           src_flag_q;
    logic [COL_IDX_WIDTH-1:0]       wgt_addr;

    logic signed [DATA_WIDTH-1:0]   val_p1;
    logic                           vld_p1;
    logic signed [PROD_W-1:0]       val_ext_p1;
    logic signed [PROD_W-1:0]       wgt_ext_p1 [NUM_LANES];
    logic signed [PROD_W-1:0]       prod_p1    [NUM_LANES];
    logic signed [SUM_W-1:0]        sum_p1     [NUM_LANES];
    logic signed [ACC_WIDTH-1:0]    nxt_p1     [NUM_LANES];
    logic [NUM_LANES-1:0]           lane_ovf_p1;

    logic signed [ACC_WIDTH-1:0]    acc_p2 [NUM_LANES];
    logic                           ovf_p2;
    logic [NUM_LANES*ACC_WIDTH-1:0] res_flat;

    // Out of range when the bits from the ACC_WIDTH sign bit upward are not all equal.
    function automatic logic sum_ovf(input logic signed [SUM_W-1:0] s);
        logic [SUM_W-ACC_WIDTH:0] top;
        top = s[SUM_W-1:ACC_WIDTH-1];
        return !((&top) || !(|top));
    endfunction

    // Clamp to the nearest bound, or keep the low bits (two's-complement wrap).
    function automatic logic signed [ACC_WIDTH-1:0] sat_sum(input logic signed [SUM_W-1:0] s);
        if (!sum_ovf(s) || (SATURATE == 0))
            return s[ACC_WIDTH-1:0];
        else if (s[SUM_W-1])
            return {1'b1, {(ACC_WIDTH-1){1'b0}}};
        else
            return {1'b0, {(ACC_WIDTH-1){1'b1}}};
    endfunction

    // Control FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        row_rdy   = 1'b0;
        nz_rdy    = 1'b0;
        res_vld   = 1'b0;
        case (state)
            IDLE: begin
                row_rdy = 1'b1;
                if (bus.row_vld_i)
                    state_nxt = (bus.row_len_i == '0) ? OUT : ACC;
            end
            ACC: begin
                nz_rdy = 1'b1;
                if (bus.nz_vld_i && last_nz)
                    state_nxt = WAIT;
            end
            WAIT: state_nxt = OUT;
            OUT: begin
                res_vld = 1'b1;
                if (bus.res_rdy_i)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign row_fire = row_rdy && bus.row_vld_i;
    assign nz_fire  = nz_rdy && bus.nz_vld_i;
    assign res_fire = res_vld && bus.res_rdy_i;
    assign last_nz  = (nz_cnt_q == (row_len_q - ROW_LEN_WIDTH'(1)));

    // Row header latch and nonzero counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_len_q  <= '0;
            nz_cnt_q   <= '0;
            mode_q     <= 1'b0;
            num_node_q <= '0;
            src_flag_q <= 1'b0;
        end else if (row_fire) begin
            row_len_q  <= bus.row_len_i;
            nz_cnt_q   <= '0;
            mode_q     <= bus.mode_i;
            num_node_q <= bus.num_node_i;
            src_flag_q <= bus.src_flag_i;
        end else if (nz_fire) begin
            nz_cnt_q   <= nz_cnt_q + ROW_LEN_WIDTH'(1);
        end
    end

    // ---- p0 -> p1: the nonzero value waits one cycle for the BRAM read ----
    assign wgt_addr       = bus.col_idx_i;
    assign bus.wgt_addr_o = wgt_addr;

    always_ff @(posedge clk) begin
        if (nz_fire) val_p1 <= bus.val_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p1 <= 1'b0;
        else        vld_p1 <= nz_fire;
    end

    // ---- p1: weight row arrives; form lane products and saturated sums ----
    assign val_ext_p1 = {{WGT_WIDTH{val_p1[DATA_WIDTH-1]}}, val_p1};

    always_comb begin
        lane_ovf_p1 = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            wgt_ext_p1[k] = {{DATA_WIDTH{bus.wgt_dout_i[k*WGT_WIDTH+WGT_WIDTH-1]}},
                             bus.wgt_dout_i[k*WGT_WIDTH +: WGT_WIDTH]};
            prod_p1[k]    = mode_q ? (val_ext_p1 * wgt_ext_p1[k]) : wgt_ext_p1[k];
            sum_p1[k]     = {{(SUM_W-ACC_WIDTH){acc_p2[k][ACC_WIDTH-1]}}, acc_p2[k]}
                          + {{(SUM_W-PROD_W){prod_p1[k][PROD_W-1]}}, prod_p1[k]};
            nxt_p1[k]      = sat_sum(sum_p1[k]);
            lane_ovf_p1[k] = sum_ovf(sum_p1[k]);
        end
    end

    // ---- p1 -> p2: accumulators and sticky overflow ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_LANES; k++) acc_p2[k] <= '0;
            ovf_p2 <= 1'b0;
        end else if (row_fire) begin
            for (int k = 0; k < NUM_LANES; k++) acc_p2[k] <= '0;
            ovf_p2 <= 1'b0;
        end else if (vld_p1) begin
            for (int k = 0; k < NUM_LANES; k++) acc_p2[k] <= nxt_p1[k];
            ovf_p2 <= ovf_p2 | (|lane_ovf_p1);
        end
    end

    always_comb begin
        res_flat = '0;
        for (int k = 0; k < NUM_LANES; k++)
            res_flat[k*ACC_WIDTH +: ACC_WIDTH] = acc_p2[k];
    end

    assign bus.row_rdy_o  = row_rdy;
    assign bus.nz_rdy_o   = nz_rdy;
    assign bus.res_vld_o  = res_vld;
    assign bus.res_o      = res_flat;
    assign bus.ovf_o      = ovf_p2;
    assign bus.num_node_o = num_node_q;
    assign bus.src_flag_o = src_flag_q;

    // res_fire only matters through state_nxt; kept as a named handshake term.
    logic unused_res_fire;
    assign unused_res_fire = res_fire;
endmodule

// File: tb/tb_sp_pe_mac.sv
// Directed bench for sp_pe_mac with NUM_LANES=2, ACC_WIDTH=12.
// Two instances share all stimulus: one saturating, one wrapping.
module tb_sp_pe_mac;
    localparam int NL = 2;
    localparam int AW = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int t_row, t_last, t_res, t_hs;

    always @(posedge clk) cyc <= cyc + 1;

    sp_pe_mac_if #(.NUM_LANES(NL)) bs ();
    sp_pe_mac_if #(.NUM_LANES(NL)) bw ();

    sp_pe_mac #(.NUM_LANES(NL), .SATURATE(1)) dut_sat  (.clk(clk), .rst_n(rst_n), .bus(bs));
    sp_pe_mac #(.NUM_LANES(NL), .SATURATE(0)) dut_wrap (.clk(clk), .rst_n(rst_n), .bus(bw));

    assign bw.mode_i     = bs.mode_i;
    assign bw.row_vld_i  = bs.row_vld_i;
    assign bw.row_len_i  = bs.row_len_i;
    assign bw.num_node_i = bs.num_node_i;
    assign bw.src_flag_i = bs.src_flag_i;
    assign bw.nz_vld_i   = bs.nz_vld_i;
    assign bw.col_idx_i  = bs.col_idx_i;
    assign bw.val_i      = bs.val_i;
    assign bw.res_rdy_i  = bs.res_rdy_i;
    assign bw.wgt_dout_i = bs.wgt_dout_i;

    // Weight BRAM model, 1-cycle read latency.
    logic [2*8-1:0] wmem [2048];
    always @(posedge clk) bs.wgt_dout_i <= wmem[bs.wgt_addr_o];

    function automatic logic [2*AW-1:0] pk(input int l0, input int l1);
        logic [AW-1:0] a, b;
        a = AW'(l0);
        b = AW'(l1);
        return {b, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setw(input int col, input int l0, input int l1);
        logic [7:0] a, b;
        a = 8'(l0);
        b = 8'(l1);
        wmem[col] = {b, a};
    endtask

    task automatic row(input int len, input logic m, input int nn, input logic sf);
        int n;
        bs.row_len_i  = 11'(len);
        bs.mode_i     = m;
        bs.num_node_i = 8'(nn);
        bs.src_flag_i = sf;
        bs.row_vld_i  = 1'b1;
        n = 0;
        while (!bs.row_rdy_o && n < 100) begin @(negedge clk); n++; end
        check("row_rdy", 64'(bs.row_rdy_o), 64'(1));
        t_row = cyc;
        @(negedge clk);
        bs.row_vld_i = 1'b0;
    endtask

    task automatic nz(input int col, input int v);
        int n;
        bs.col_idx_i = 11'(col);
        bs.val_i     = 8'(v);
        bs.nz_vld_i  = 1'b1;
        n = 0;
        while (!bs.nz_rdy_o && n < 100) begin @(negedge clk); n++; end
        check("nz_rdy", 64'(bs.nz_rdy_o), 64'(1));
        t_last = cyc;
        @(negedge clk);
        bs.nz_vld_i = 1'b0;
    endtask

    task automatic wait_res();
        int n;
        n = 0;
        while (!bs.res_vld_o && n < 100) begin @(negedge clk); n++; end
        check("res_vld", 64'(bs.res_vld_o), 64'(1));
        t_res = cyc;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_row_rdy"},  64'(bs.row_rdy_o),  64'(1));
        check({tag, "_nz_rdy"},   64'(bs.nz_rdy_o),   64'(0));
        check({tag, "_res_vld"},  64'(bs.res_vld_o),  64'(0));
        check({tag, "_res"},      64'(bs.res_o),      64'(0));
        check({tag, "_ovf"},      64'(bs.ovf_o),      64'(0));
        check({tag, "_num_node"}, 64'(bs.num_node_o), 64'(0));
        check({tag, "_src_flag"}, 64'(bs.src_flag_o), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) wmem[i] = '0;
        setw(1, 1, -2);    setw(2, 3, 4);    setw(3, -5, 6);
        setw(10, 10, -7);  setw(11, 4, 5);
        setw(40, 127, -128);
        setw(20, 100, -100); setw(21, -3, 5);
        setw(30, 7, 7);

        bs.mode_i = 1'b0;   bs.row_vld_i = 1'b0; bs.row_len_i = '0;
        bs.num_node_i = '0; bs.src_flag_i = 1'b0;
        bs.nz_vld_i = 1'b0; bs.col_idx_i = '0;   bs.val_i = '0;
        bs.res_rdy_i = 1'b1;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Mode 0, three nonzeros back to back; val is ignored
        row(3, 1'b0, 11, 1'b0);
        nz(1, -7); nz(2, -7); nz(3, -7);
        wait_res();
        check("m0_latency", 64'(t_res - t_last), 64'(2));
        check("m0_res",     64'(bs.res_o),      64'(pk(-1, 8)));
        check("m0_ovf",     64'(bs.ovf_o),      64'(0));
        check("m0_num_node",64'(bs.num_node_o), 64'(11));
        check("m0_wrap_res",64'(bw.res_o),      64'(pk(-1, 8)));

        // Mode 1, back to back
        row(2, 1'b1, 4, 1'b1);
        nz(10, 3); nz(11, -2);
        wait_res();
        check("m1_latency", 64'(t_res - t_last), 64'(2));
        check("m1_res",     64'(bs.res_o),      64'(pk(22, -31)));
        check("m1_src_flag",64'(bs.src_flag_o), 64'(1));

        // Mode 1 with two idle cycles between nonzeros
        row(2, 1'b1, 4, 1'b1);
        nz(10, 3);
        repeat (2) @(negedge clk);
        nz(11, -2);
        wait_res();
        check("gap_latency", 64'(t_res - t_last), 64'(2));
        check("gap_res",     64'(bs.res_o),      64'(pk(22, -31)));
        check("gap_ovf",     64'(bs.ovf_o),      64'(0));

        // Overflow: 20 x 127*(127,-128)
        row(20, 1'b1, 2, 1'b0);
        for (int i = 0; i < 20; i++) nz(40, 127);
        wait_res();
        check("sat_res",  64'(bs.res_o),     64'(pk(2047, -2048)));
        check("sat_ovf",  64'(bs.ovf_o),     64'(1));
        check("wrap_vld", 64'(bw.res_vld_o), 64'(1));
        check("wrap_res", 64'(bw.res_o),     64'(pk(-1004, -1536)));
        check("wrap_ovf", 64'(bw.ovf_o),     64'(1));

        // Zero-length row
        row(0, 1'b0, 5, 1'b1);
        wait_res();
        check("zl_latency",  64'(t_res - t_row),  64'(1));
        check("zl_res",      64'(bs.res_o),      64'(0));
        check("zl_ovf",      64'(bs.ovf_o),      64'(0));
        check("zl_num_node", 64'(bs.num_node_o), 64'(5));
        check("zl_src_flag", 64'(bs.src_flag_o), 64'(1));
        @(negedge clk);

        // Backpressure on the result port
        bs.res_rdy_i = 1'b0;
        row(1, 1'b0, 9, 1'b0);
        nz(20, 0);
        wait_res();
        bs.row_len_i = 11'd1; bs.mode_i = 1'b0; bs.num_node_i = 8'd3; bs.src_flag_i = 1'b1;
        bs.row_vld_i = 1'b1;
        bs.col_idx_i = 11'd21; bs.val_i = 8'd0; bs.nz_vld_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_res_vld",  64'(bs.res_vld_o),  64'(1));
            check("bp_res",      64'(bs.res_o),      64'(pk(100, -100)));
            check("bp_num_node", 64'(bs.num_node_o), 64'(9));
            check("bp_src_flag", 64'(bs.src_flag_o), 64'(0));
            check("bp_ovf",      64'(bs.ovf_o),      64'(0));
            check("bp_row_rdy",  64'(bs.row_rdy_o),  64'(0));
            check("bp_nz_rdy",   64'(bs.nz_rdy_o),   64'(0));
            @(negedge clk);
        end
        bs.res_rdy_i = 1'b1;
        t_hs = cyc;
        check("hs_row_rdy_same", 64'(bs.row_rdy_o), 64'(0));
        @(negedge clk);
        check("hs1_row_rdy", 64'(bs.row_rdy_o), 64'(1));
        check("hs1_nz_rdy",  64'(bs.nz_rdy_o),  64'(0));
        @(negedge clk);
        bs.row_vld_i = 1'b0;
        check("hs2_nz_rdy",  64'(bs.nz_rdy_o),  64'(1));
        check("hs2_cycle",   64'(cyc - t_hs),   64'(2));
        @(negedge clk);
        bs.nz_vld_i = 1'b0;
        wait_res();
        check("bp_next_res",      64'(bs.res_o),      64'(pk(-3, 5)));
        check("bp_next_num_node", 64'(bs.num_node_o), 64'(3));
        check("bp_next_src_flag", 64'(bs.src_flag_o), 64'(1));
        @(negedge clk);

        // Reset in the middle of a row
        row(5, 1'b1, 7, 1'b1);
        nz(30, 1); nz(30, 1);
        check("mid_num_node", 64'(bs.num_node_o), 64'(7));
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        row(1, 1'b0, 0, 1'b0);
        nz(30, 0);
        wait_res();
        check("post_rst_res", 64'(bs.res_o), 64'(pk(7, 7)));
        check("post_rst_ovf", 64'(bs.ovf_o), 64'(0));
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
